alu_result_capture: RTL and testbench
=====================================

Name: alu_result_capture

Overview:
- Downstream stage of the lab ALU. Registers the 8-bit ALU result when a pushbutton is pressed.
- Feeds the low nibble of the registered result back as the ALU B operand, turning the ALU into an accumulator.
- Keeps a small history ring of captured results that the user steps through on the HEX displays.
- Sits between the ALU output and the LEDR/HEX display decoders.

Parameters:
DATA_W, 8, width of ALU result captured and stored
DEPTH, 4, number of history entries (power of two, >=2)
PTR_W, 2, log2(DEPTH); width of history pointers

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
alu_out  input  DATA_W  combinational result from ALU
capture_n  input  1  raw active-low pushbutton; press = capture
step_n  input  1  raw active-low pushbutton; press = show next-older history entry
result  output  DATA_W  most recently captured ALU result (drives LEDR)
feedback_b  output  4  result[3:0]; drives ALU B operand
disp_val  output  DATA_W  history entry currently selected for HEX display
hist_count  output  PTR_W+1  number of valid history entries, 0..DEPTH
view_idx  output  PTR_W  selected entry age, 0 = newest
overflow  output  1  sticky; set when a capture overwrites an entry

Behaviour:
- Reset (async, active-high): result=0, all history entries=0, write pointer=0, hist_count=0, view_idx=0, overflow=0, all synchronizer and edge flops=0. Outputs reach these values immediately on reset assertion, with no clock required.
- Button conditioning, identical for capture_n and step_n:
  - Input is inverted to active-high, then passed through a 2-flop synchronizer (s1, s2) and a delay flop s2_d.
  - pulse = s2 & ~s2_d, one cycle wide.
  - A button first sampled pressed at edge N gives s2=1 after edge N+1; the pulse is high in cycle N+1..N+2 and acts at edge N+2.
  - Holding the button produces exactly one pulse. Release produces none.
  - A button held through reset deassertion produces exactly one pulse, 2 edges after the first post-reset sample.
- Capture, at an edge with cap_pulse=1:
  - result <= alu_out as sampled at that edge.
  - hist[wp] <= alu_out; wp <= wp+1 mod DEPTH.
  - hist_count <= min(hist_count+1, DEPTH).
  - If hist_count==DEPTH before the capture, the oldest entry is overwritten and overflow <= 1. overflow stays 1 until reset.
  - view_idx <= 0.
- Step, at an edge with step_pulse=1 and no cap_pulse:
  - If hist_count==0, view_idx stays 0.
  - Otherwise view_idx <= (view_idx+1) mod hist_count, wrapping from oldest back to newest.
- Simultaneous cap_pulse and step_pulse: capture wins, view_idx=0, and the step is dropped.
- disp_val, combinational from registered state:
  - 0 when hist_count==0.
  - Otherwise hist[(wp-1-view_idx) mod DEPTH].
- feedback_b = result[3:0] at all times, so the new operand reaches the ALU one cycle after capture.
- Latency: capture_n falling and first sampled at edge N → result and disp_val updated after edge N+2.
- No combinational path from alu_out to any output; all outputs are registered or decode registered state.

Test Plan:
- Reset: assert reset mid-cycle with no clock → result=0x00, disp_val=0x00, hist_count=0, overflow=0, view_idx=0; step press while empty → view_idx stays 0.
- Single capture: alu_out=0x5A, press capture_n for 10 cycles → exactly one capture at edge N+2; result=0x5A, feedback_b=0xA, hist_count=1, disp_val=0x5A.
- Accumulate: captures of 0x03, 0x07, 0x0C → hist_count=3. Steps then show disp_val 0x0C → 0x07 → 0x03 → 0x0C (wrap at hist_count). feedback_b=0xC.
- Overflow: capture 0x11, 0x22, 0x33, 0x44, 0x55 → hist_count=4, overflow=1, newest=0x55. Three steps → disp_val 0x22 (0x11 gone). overflow stays 1 after further captures.
- Simultaneous: with view_idx=2, press both buttons so pulses coincide, alu_out=0x99 → result=0x99, view_idx=0, disp_val=0x99, no extra step.
- Reset during hold: hold capture_n low, assert then deassert reset → state cleared, then exactly one capture 2 edges after the first post-reset sample; keep holding 20 cycles → no further capture.

Source files
------------

// File: rtl/alu_result_capture.sv
// Capture stage behind the lab ALU: registers the ALU result on a button press,
// feeds its low nibble back as operand B, and keeps a browsable history ring.

module alu_button_pulse (
  input  logic clk,
  input  logic reset,
  input  logic button_n,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s2_d;

  // Two-flop synchronizer on the inverted button, then a delay flop for the rising-edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= ~button_n;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign pulse = s2 & ~s2_d;

endmodule

module alu_result_capture #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              capture_n,
  input  logic              step_n,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        feedback_b,
  output logic [DATA_W-1:0] disp_val,
  output logic [PTR_W:0]    hist_count,
  output logic [PTR_W-1:0]  view_idx,
  output logic              overflow
);

  logic              cap_pulse;
  logic              step_pulse;
  logic [DATA_W-1:0] hist [DEPTH];
  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rd_idx;
  logic [PTR_W:0]    view_next;

  alu_button_pulse u_cap_btn (
    .clk      (clk),
    .reset    (reset),
    .button_n (capture_n),
    .pulse    (cap_pulse)
  );

  alu_button_pulse u_step_btn (
    .clk      (clk),
    .reset    (reset),
    .button_n (step_n),
    .pulse    (step_pulse)
  );

  // view_idx is always below hist_count, so one compare implements the modulo wrap
  assign view_next = {1'b0, view_idx} + (PTR_W+1)'(1);

  // Capture takes priority over step; a step that coincides with a capture is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result     <= '0;
      wp         <= '0;
      hist_count <= '0;
      view_idx   <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (cap_pulse) begin
      result   <= alu_out;
      hist[wp] <= alu_out;
      wp       <= wp + PTR_W'(1);
      view_idx <= '0;
      if (hist_count == (PTR_W+1)'(DEPTH)) overflow <= 1'b1;
      else hist_count <= hist_count + (PTR_W+1)'(1);
    end else if (step_pulse && hist_count != '0) begin
      if (view_next >= hist_count) view_idx <= '0;
      else view_idx <= view_next[PTR_W-1:0];
    end
  end

  // Newest entry sits just behind the write pointer; older entries further back
  assign rd_idx     = wp - PTR_W'(1) - view_idx;
  assign disp_val   = (hist_count == '0) ? '0 : hist[rd_idx];
  assign feedback_b = result[3:0];

endmodule

// File: tb/tb_alu_result_capture.sv
// Scoreboard bench for alu_result_capture: stimulus queues hand-computed
// snapshots tagged with the clock edge they should follow; a monitor compares.

module tb_alu_result_capture;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] alu_out = 8'h00;
  logic       capture_n = 1'b1;
  logic       step_n = 1'b1;
  logic [7:0] result;
  logic [3:0] feedback_b;
  logic [7:0] disp_val;
  logic [2:0] hist_count;
  logic [1:0] view_idx;
  logic       overflow;

  typedef struct {
    int         at;
    string      name;
    logic [7:0] res;
    logic [7:0] disp;
    logic [2:0] cnt;
    logic [1:0] view;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  exp_t prev;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_result_capture #(.DATA_W(8), .DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_out    (alu_out),
    .capture_n  (capture_n),
    .step_n     (step_n),
    .result     (result),
    .feedback_b (feedback_b),
    .disp_val   (disp_val),
    .hist_count (hist_count),
    .view_idx   (view_idx),
    .overflow   (overflow)
  );

  // Clock can be held low so reset is shown to act without any edge
  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkField(input string tag, input string field,
                            input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s.%s: got 0x%02h, expected 0x%02h (cycle %0d)", tag, field, act, req, cyc);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField(e.name, "result",     result,              e.res);
    checkField(e.name, "feedback_b", {4'h0, feedback_b},  {4'h0, e.res[3:0]});
    checkField(e.name, "disp_val",   disp_val,            e.disp);
    checkField(e.name, "hist_count", {5'h0, hist_count},  {5'h0, e.cnt});
    checkField(e.name, "view_idx",   {6'h0, view_idx},    {6'h0, e.view});
    checkField(e.name, "overflow",   {7'h0, overflow},    {7'h0, e.ovf});
  endtask

  function automatic exp_t mk(input int at, input string name, input logic [7:0] res,
                              input logic [7:0] disp, input logic [2:0] cnt,
                              input logic [1:0] view, input logic ovf);
    exp_t e;
    e.at = at; e.name = name; e.res = res; e.disp = disp;
    e.cnt = cnt; e.view = view; e.ovf = ovf;
    return e;
  endfunction

  // Monitor: after each edge, compare every snapshot due at that edge
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.at < cyc) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s.missed: checked at cycle %0d, expected at %0d", e.name, cyc, e.at);
      end else begin
        checkOutput(e);
      end
    end
  end

  // Press the selected buttons, hold, release; the press is first sampled at base+1
  // so its pulse acts at edge base+3. Old state must still show at base+2 and the
  // new state must persist to the end of the hold (no repeat pulse).
  task automatic applyStimulus(input string name, input bit cap, input bit stp,
                               input logic [7:0] alu, input int hold,
                               input logic [7:0] e_res, input logic [7:0] e_disp,
                               input logic [2:0] e_cnt, input logic [1:0] e_view,
                               input logic e_ovf);
    int base;
    exp_t pre;
    @(posedge clk); #1;
    alu_out = alu;
    if (cap) capture_n = 1'b0;
    if (stp) step_n = 1'b0;
    base = cyc;
    pre = prev;
    pre.at = base + 2;
    pre.name = {name, "_pre"};
    q.push_back(pre);
    prev = mk(base + 3, name, e_res, e_disp, e_cnt, e_view, e_ovf);
    q.push_back(prev);
    q.push_back(mk(base + hold + 2, {name, "_hold"}, e_res, e_disp, e_cnt, e_view, e_ovf));
    repeat (hold) @(posedge clk);
    #1;
    capture_n = 1'b1;
    step_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic doReset(input string name);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checkOutput(mk(0, name, 8'h00, 8'h00, 3'd0, 2'd0, 1'b0));
    @(posedge clk); #1;
    reset = 1'b0;
    prev = mk(0, "", 8'h00, 8'h00, 3'd0, 2'd0, 1'b0);
  endtask

  initial begin
    int base;
    // Reset with the clock stopped
    #3 reset = 1'b1;
    #1 checkOutput(mk(0, "reset_noclk", 8'h00, 8'h00, 3'd0, 2'd0, 1'b0));
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    prev = mk(0, "", 8'h00, 8'h00, 3'd0, 2'd0, 1'b0);

    applyStimulus("step_empty", 0, 1, 8'h00, 4, 8'h00, 8'h00, 3'd0, 2'd0, 1'b0);
    applyStimulus("single_cap", 1, 0, 8'h5A, 10, 8'h5A, 8'h5A, 3'd1, 2'd0, 1'b0);

    doReset("reset_acc");
    applyStimulus("acc_03", 1, 0, 8'h03, 4, 8'h03, 8'h03, 3'd1, 2'd0, 1'b0);
    applyStimulus("acc_07", 1, 0, 8'h07, 4, 8'h07, 8'h07, 3'd2, 2'd0, 1'b0);
    applyStimulus("acc_0C", 1, 0, 8'h0C, 4, 8'h0C, 8'h0C, 3'd3, 2'd0, 1'b0);
    applyStimulus("acc_step1", 0, 1, 8'h00, 4, 8'h0C, 8'h07, 3'd3, 2'd1, 1'b0);
    applyStimulus("acc_step2", 0, 1, 8'h00, 4, 8'h0C, 8'h03, 3'd3, 2'd2, 1'b0);
    applyStimulus("acc_wrap", 0, 1, 8'h00, 4, 8'h0C, 8'h0C, 3'd3, 2'd0, 1'b0);

    doReset("reset_ovf");
    applyStimulus("ovf_11", 1, 0, 8'h11, 4, 8'h11, 8'h11, 3'd1, 2'd0, 1'b0);
    applyStimulus("ovf_22", 1, 0, 8'h22, 4, 8'h22, 8'h22, 3'd2, 2'd0, 1'b0);
    applyStimulus("ovf_33", 1, 0, 8'h33, 4, 8'h33, 8'h33, 3'd3, 2'd0, 1'b0);
    applyStimulus("ovf_44", 1, 0, 8'h44, 4, 8'h44, 8'h44, 3'd4, 2'd0, 1'b0);
    applyStimulus("ovf_55", 1, 0, 8'h55, 4, 8'h55, 8'h55, 3'd4, 2'd0, 1'b1);
    applyStimulus("ovf_step1", 0, 1, 8'h00, 4, 8'h55, 8'h44, 3'd4, 2'd1, 1'b1);
    applyStimulus("ovf_step2", 0, 1, 8'h00, 4, 8'h55, 8'h33, 3'd4, 2'd2, 1'b1);
    applyStimulus("ovf_step3", 0, 1, 8'h00, 4, 8'h55, 8'h22, 3'd4, 2'd3, 1'b1);
    applyStimulus("ovf_66", 1, 0, 8'h66, 4, 8'h66, 8'h66, 3'd4, 2'd0, 1'b1);
    applyStimulus("sim_step1", 0, 1, 8'h00, 4, 8'h66, 8'h55, 3'd4, 2'd1, 1'b1);
    applyStimulus("sim_step2", 0, 1, 8'h00, 4, 8'h66, 8'h44, 3'd4, 2'd2, 1'b1);
    applyStimulus("simultaneous", 1, 1, 8'h99, 6, 8'h99, 8'h99, 3'd4, 2'd0, 1'b1);

    // Button held across a reset pulse: one capture after release of reset, no more
    @(posedge clk); #1;
    alu_out = 8'h77;
    capture_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1 checkOutput(mk(0, "hold_reset", 8'h00, 8'h00, 3'd0, 2'd0, 1'b0));
    @(posedge clk); #1;
    reset = 1'b0;
    base = cyc;
    q.push_back(mk(base + 2, "hold_pre", 8'h00, 8'h00, 3'd0, 2'd0, 1'b0));
    q.push_back(mk(base + 3, "hold_cap", 8'h77, 8'h77, 3'd1, 2'd0, 1'b0));
    q.push_back(mk(base + 23, "hold_long", 8'h77, 8'h77, 3'd1, 2'd0, 1'b0));
    repeat (24) @(posedge clk);
    #1 capture_n = 1'b1;
    repeat (3) @(posedge clk);

    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s.unchecked: never compared, expected at cycle %0d", e.name, e.at);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: stimulus still running at cycle %0d, expected done", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] timeout");
  end

endmodule
